// File: rtl/seg7_pkg.sv
// Shared glyph constants, decode function and FIFO entry type for the seven-segment decoder.
// SEG7_DP_EN adds a decimal-point bit to each queued entry.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK   = 7'h00;
  localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h71;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } seg7_code_t;

`ifdef SEG7_DP_EN
  typedef struct packed {
    logic       dp;
    logic       err;
    logic [3:0] digit;
  } seg7_entry_t;
`else
  typedef seg7_code_t seg7_entry_t;
`endif

  // Blank decodes to a clean zero; it is filtered out before any push.
  function automatic seg7_code_t seg7_decode(input logic [6:0] pattern);
    seg7_code_t code;
    code.err   = 1'b0;
    code.digit = 4'h0;
    case (pattern)
      SEG7_GLYPH_0: code.digit = 4'h0;
      SEG7_GLYPH_1: code.digit = 4'h1;
      SEG7_GLYPH_2: code.digit = 4'h2;
      SEG7_GLYPH_3: code.digit = 4'h3;
      SEG7_GLYPH_4: code.digit = 4'h4;
      SEG7_GLYPH_5: code.digit = 4'h5;
      SEG7_GLYPH_6: code.digit = 4'h6;
      SEG7_GLYPH_7: code.digit = 4'h7;
      SEG7_GLYPH_8: code.digit = 4'h8;
      SEG7_GLYPH_9: code.digit = 4'h9;
      SEG7_GLYPH_A: code.digit = 4'hA;
      SEG7_GLYPH_B: code.digit = 4'hB;
      SEG7_GLYPH_C: code.digit = 4'hC;
      SEG7_GLYPH_D: code.digit = 4'hD;
      SEG7_GLYPH_E: code.digit = 4'hE;
      SEG7_GLYPH_F: code.digit = 4'hF;
      SEG7_BLANK:   code.digit = 4'h0;
      default:      code.err   = 1'b1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_sync_fifo.sv
// Single-clock FIFO with registered occupancy. A push into a full FIFO is accepted only
// when a pop happens on the same edge.
module seg7_sync_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the head is only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/seg7_decoder.sv
// Samples a seven-segment bus, accepts glyphs held steady for STABLE_CYCLES edges and queues
// the decoded hex values. SEG7_DP_EN adds the dp_in/out_dp decimal-point path.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [6:0]                  seg_in,
`ifdef SEG7_DP_EN
  input  logic                        dp_in,
  output logic                        out_dp,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_digit,
  output logic                        out_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

`ifdef SEG7_DP_EN
  localparam int unsigned SampleW = 8;
`else
  localparam int unsigned SampleW = 7;
`endif
  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
  localparam logic [3:0] StableAcc = 4'(STABLE_CYCLES - 1);

  logic [SampleW-1:0] sample, r_q;
  logic [3:0]         cnt_q, cnt_d;
  logic               overflow_q, overflow_d;
  logic               match, blank, accept, push, pop, full, empty;
  seg7_code_t         code;
  seg7_entry_t        entry, head;

`ifdef SEG7_DP_EN
  assign sample = {dp_in, seg_in};
`else
  assign sample = seg_in;
`endif

  assign match  = (sample == r_q);
  assign blank  = (seg_in == SEG7_BLANK);
  // cnt saturates, so this fires once per stable run.
  assign accept = ena && match && (cnt_q == StableAcc);
  assign push   = accept && !blank;
  assign pop    = out_valid && out_ready;
  assign code   = seg7_decode(seg_in);

  always_comb begin
    entry.err   = code.err;
    entry.digit = code.digit;
`ifdef SEG7_DP_EN
    entry.dp    = dp_in;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!ena || !match) begin
      cnt_d = '0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign overflow_d = overflow_q || (push && full && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      r_q        <= sample;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  seg7_sync_fifo #(
    .Width ($bits(seg7_entry_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign out_valid = !empty;
  assign out_digit = out_valid ? head.digit : 4'h0;
  assign out_err   = out_valid && head.err;
  assign overflow  = overflow_q;
`ifdef SEG7_DP_EN
  assign out_dp    = out_valid && head.dp;
`endif

endmodule

// File: tb/tb_seg7_decoder.sv
// Randomised and directed stimulus for seg7_decoder, checked each cycle against a
// run-length / queue reference model.
module tb_seg7_decoder;

  localparam int unsigned S = 4;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, out_ready;
  logic [6:0] seg_in;
  logic       out_valid, out_err, overflow;
  logic [3:0] out_digit;
  logic [2:0] fifo_count;
`ifdef SEG7_DP_EN
  logic       dp_in = 1'b0;
  logic       out_dp;
`endif

  always #5 clk = ~clk;

  seg7_decoder #(
    .STABLE_CYCLES (S),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .seg_in     (seg_in),
`ifdef SEG7_DP_EN
    .dp_in      (dp_in),
    .out_dp     (out_dp),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digit  (out_digit),
    .out_err    (out_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned glyph [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                              'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  // Model: expected queue of {err, digit}, previous sample, qualifying run length.
  logic [4:0] exp_q [$];
  logic [6:0] prev_seg;
  int         run_len;
  logic       exp_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == 32'(p)) return {1'b0, 4'(i)};
    end
    return 5'b1_0000;
  endfunction

  task automatic check_outputs();
    logic       has;
    logic [4:0] hd;
    has = (exp_q.size() > 0);
    hd  = has ? exp_q[0] : 5'b0;
    check("out_valid",  32'(out_valid),  32'(has));
    check("out_digit",  32'(out_digit),  32'(hd[3:0]));
    check("out_err",    32'(out_err),    32'(hd[4]));
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check("overflow",   32'(overflow),   32'(exp_ovf));
  endtask

  // Called just after a negedge: check, drive, model the coming posedge, return at next negedge.
  task automatic step(input logic [6:0] seg, input logic en, input logic rdy);
    logic pop, full, push;
    check_outputs();
    seg_in    = seg;
    ena       = en;
    out_ready = rdy;
    pop  = (exp_q.size() > 0) && rdy;
    full = (exp_q.size() == D);
    // A glyph is accepted when it has been seen on S+1 consecutive samples, with ena on the last S.
    run_len  = (en && seg == prev_seg) ? run_len + 1 : 0;
    push     = (run_len == S) && (seg != 7'h00);
    prev_seg = seg;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (!full || pop) exp_q.push_back(ref_decode(seg));
      else exp_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [6:0] seg, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(seg, 1'b1, rdy);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid),  32'd0);
    check("rst_digit", 32'(out_digit),  32'd0);
    check("rst_err",   32'(out_err),    32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    exp_q.delete();
    prev_seg = 7'h00;
    run_len  = 0;
    exp_ovf  = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b0;
    seg_in    = 7'h00;
    out_ready = 1'b0;
    prev_seg  = 7'h00;
    run_len   = 0;
    exp_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single digit 3, then drain.
    hold(7'h4F, 5, 1'b1);
    hold(7'h00, 3, 1'b1);
    // Short glitch: no push.
    hold(7'h06, 3, 1'b1);
    hold(7'h00, 3, 1'b1);
    // Repeated digit split by blank, then d.
    hold(7'h3F, 6, 1'b0);
    hold(7'h00, 2, 1'b0);
    hold(7'h3F, 6, 1'b0);
    hold(7'h5E, 6, 1'b0);
    hold(7'h00, 5, 1'b1);
    // Unrecognised glyph.
    hold(7'h41, 8, 1'b1);
    hold(7'h00, 3, 1'b1);
    // Overflow: five digits into a four-deep queue.
    for (int d = 1; d <= 5; d++) hold(7'(glyph[d]), 6, 1'b0);
    hold(7'h00, 6, 1'b1);
    mid_reset();
    // Pop coincides with the fifth push: nothing dropped.
    for (int d = 1; d <= 4; d++) hold(7'(glyph[d]), 5, 1'b0);
    hold(7'(glyph[5]), 4, 1'b0);
    step(7'(glyph[5]), 1'b1, 1'b1);
    hold(7'(glyph[5]), 2, 1'b0);
    hold(7'h00, 6, 1'b1);
    // Reset with two entries queued and a partial count, then glyph needs a full run again.
    hold(7'(glyph[7]), 5, 1'b0);
    hold(7'(glyph[8]), 5, 1'b0);
    hold(7'(glyph[9]), 3, 1'b0);
    mid_reset();
    hold(7'(glyph[9]), 7, 1'b0);
    hold(7'h00, 3, 1'b1);

    // Random runs of glyphs, blanks, glitches, errors, with ena and ready toggling.
    for (int ph = 0; ph < 400; ph++) begin
      int         kind, len, rdy_bias;
      logic [6:0] pat;
      kind     = int'($urandom_range(0, 9));
      len      = int'($urandom_range(1, 8));
      rdy_bias = int'($urandom_range(0, 3));
      if (kind == 0)      pat = 7'h00;
      else if (kind == 1) pat = 7'($urandom_range(0, 127));
      else                pat = 7'(glyph[$urandom_range(0, 15)]);
      for (int c = 0; c < len; c++) begin
        step(pat, $urandom_range(0, 15) != 0, $urandom_range(0, 3) < rdy_bias);
      end
      if ($urandom_range(0, 99) == 0) mid_reset();
    end
    hold(7'h00, 6, 1'b1);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_decoder.md
# seg7_decoder

Receive-side counterpart of the seven-segment display driver. It samples the 7-bit segment bus (`uo_out[6:0]` of the display design), waits for each glyph to hold steady, and decodes it back to a 4-bit hex value. Decoded values are queued in a small FIFO with a valid/ready output, so a bench or on-chip checker can read the displayed digit sequence.

## Interface

Parameters:

- `STABLE_CYCLES`, default 4: consecutive matching samples needed to accept a glyph. Range 2..15.
- `FIFO_DEPTH`, default 4: number of entries in the output queue. Must be a power of 2, ≥2.

Ports:

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: when low, the block holds the stability counter at 0 and performs no pushes. FIFO pops continue.
- `seg_in` in 7: segment bus; bit0=a … bit6=g; active high.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_digit` out 4: decoded hex value at the FIFO head.
- `out_err` out 1: head entry was an unrecognised glyph; `out_digit`=0 in that case.
- `overflow` out 1: sticky; set when an accept is dropped because the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation

**Glyph table** (all other non-zero patterns decode as err):

| Digit | 0 | 1 | 2 | 3 | 4 | 5 | 6 | 7 | 8 | 9 | A | b | C | d | E | F |
|---|---|---|---|---|---|---|---|---|---|---|---|---|---|---|---|---|
| Pattern | 3F | 06 | 5B | 4F | 66 | 6D | 7D | 07 | 7F | 6F | 77 | 7C | 39 | 5E | 79 | 71 |

**Input register**
- `r` captures `seg_in` on every edge.

**Stability counter** (`cnt`, saturating at `STABLE_CYCLES`), updated each edge with `ena`=1:
- If `seg_in`==`r`: `cnt` <= min(`cnt`+1, `STABLE_CYCLES`).
- Otherwise: `cnt` <= 0.
- `ena`=0 forces `cnt` <= 0.

**Accept condition**
- Accept fires on an edge when `ena`, `seg_in`==`r`, and `cnt`==`STABLE_CYCLES`-1.
- Saturation guarantees exactly one accept per stable run.

**Blank pattern**
- 0x00 never pushes.
- A blank still resets `cnt` through the mismatch rule, so a repeated digit separated by a blank is pushed twice.

**Push**
- Entry is {err, digit} taken from the decoded `seg_in`.
- If the FIFO is full and no pop occurs that edge: drop the entry and set `overflow`.

**Pop**
- Occurs when `out_valid`&&`out_ready`.

**Full + simultaneous pop and push**
- Both happen; count is unchanged.

**Empty + push**
- No bypass: `out_valid` rises after the push edge.

**Output ordering**
- `out_digit`/`out_err` are stable while `out_valid`&&!`out_ready`.

## Timing

**Reset values**
- `r`=0, `cnt`=0, FIFO empty.
- `out_valid`=0, `out_digit`=0, `out_err`=0, `overflow`=0, `fifo_count`=0.
- Reset mid-run discards all queued entries and any partial stability count.

**Latency**
- A new glyph P first sampled at edge E0 must be present at edges E0..E`STABLE_CYCLES`.
- The push occurs at edge E`STABLE_CYCLES`; `out_valid` is high in the following cycle.
- With the default of 4: five edges of P, then `out_valid`.

**Glitches**
- A glitch of any length below `STABLE_CYCLES`+1 edges produces no push.

**Throughput**
- One pop per cycle.
- `fifo_count` is a registered value; it reflects the push and pop of the preceding edge.

## Configuration

`SEG7_DP_EN`

- **Defined:**
  - Adds input `dp_in` (1 bit, decimal point) and output `out_dp`.
  - `dp_in` is included in the stability compare and is stored in each entry.
  - A pattern of `seg_in`=0x00 with `dp_in`=1 counts as blank.
- **Undefined:**
  - Neither port exists.
  - Entries are 5 bits: {err, digit}.

## Structure

**Package `seg7_pkg`**
- The 16 glyph constants.
- The decode function (pattern → {err, digit}).
- The entry typedef, whose width depends on `SEG7_DP_EN`.
- `SEG7_BLANK` = 7'h00.

**Sub-module `seg7_sync_fifo`**
- Parameterised width and depth.
- Push, pop, full, empty and count.
- Implements the simultaneous push/pop-when-full rule.

**Top level**
- Holds the input register, stability counter, accept logic and the overflow flag.

## Test plan

1. Reset, then `seg_in`=0x4F for 5 cycles with `out_ready`=1 → single entry `out_digit`=3, `out_err`=0; `out_valid` high exactly one cycle.
2. `seg_in`=0x06 for 3 cycles, then 0x00 → no push; `fifo_count` stays 0.
3. Sequence 0x3F×6, 0x00×2, 0x3F×6 with `out_ready`=0 → `fifo_count`=2, both entries digit 0; 0x5E×6 then yields digit 0xD at the third position.
4. `seg_in`=0x41 held 8 cycles → one entry with `out_err`=1, `out_digit`=0.
5. `out_ready`=0; push 5 distinct digits (1,2,3,4,5) → `fifo_count`=4, `overflow`=1, FIFO reads back 1,2,3,4. Repeat with a pop on the 5th push edge → 5 retained, `overflow` stays 0 after reset.
6. Assert `rst_n`=0 mid-stability (`cnt`=2) and with 2 entries queued → all outputs return to reset values immediately; after release, the held glyph needs a full 5 edges to push.
